axis_video_framer: RTL and testbench
====================================

# axis_video_framer

Framing stage directly upstream of the AXI-stream output interface. Accepts a raw pixel stream over a plain valid/ready handshake, counts columns and rows against the configured image size, and drives the AXI-stream master signals with start-of-frame on `axis_user` and end-of-line on `axis_tlast`. A two-entry skid buffer registers all master outputs while sustaining one transfer per cycle under arbitrary back-pressure.

## Interface
- `AXIS_DATA_WIDTH`, `AXIS_DATA_WIDTH macro`, pixel/word width; multiple of 8
- `IMG_WIDTH`, 2560, pixels per line; ≥ 1
- `IMG_HEIGHT`, 1440, lines per frame; ≥ 1
- `CNT_WIDTH`, 16, width of `frame_cnt`
- `aclk  in  1  clock; all logic on rising edge`
- `arst  in  1  reset, asynchronous, active-high`
- `s_valid  in  1  upstream pixel valid`
- `s_ready  out  1  upstream ready`
- `s_data  in  AXIS_DATA_WIDTH  upstream pixel`
- `axis_tvalid  out  1  master valid`
- `axis_tready  in  1  slave ready`
- `axis_tdata  out  AXIS_DATA_WIDTH  pixel`
- `axis_tstrb  out  AXIS_DATA_WIDTH/8  all ones`
- `axis_tkeep  out  AXIS_DATA_WIDTH/8  all ones`
- `axis_tlast  out  1  last pixel of line`
- `axis_tid  out  1  constant 0`
- `axis_tdest  out  1  constant 0`
- `axis_user  out  1  first pixel of frame`
- `frame_done  out  1  one-cycle pulse when last pixel of a frame leaves the master port`
- `frame_cnt  out  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH`

## Operation
- Upstream accept: `s_valid && s_ready`. Downstream transfer: `axis_tvalid && axis_tready`.
- Tagging at accept: `col`, `row` counters (width clog2 of size, min 1). Tag sof = (row==0 && col==0), eol = (col==IMG_WIDTH-1). Data plus tags are stored as one entry.
- Counter update per accept: col==IMG_WIDTH-1 → col=0, and row+1 (row==IMG_HEIGHT-1 → row=0); otherwise col+1. No change without accept.
- Buffer: output register (OUT) plus skid register (SKID), occupancy 0..2.
  - EMPTY: tvalid=0; accept → OUT loaded, go to ONE.
  - ONE: accept & transfer → OUT reloaded, stay; accept only → SKID loaded, go to FULL; transfer only → EMPTY.
  - FULL: s_ready=0; transfer → SKID moves to OUT, go to ONE.
- `s_ready` = !FULL, registered (derived from state flop, not from `axis_tready`).
- `axis_tvalid` = state != EMPTY; outputs driven from OUT only; held stable while tvalid && !tready.
- `frame_done` pulses for one cycle on the transfer of an entry carrying eol with row==IMG_HEIGHT-1 (stored as a third tag); `frame_cnt` increments in the same cycle.
- IMG_WIDTH==1: every pixel has eol. IMG_HEIGHT==1: every line's first pixel has sof.

## Timing
- Reset (arst high, async): state EMPTY, col=row=0, frame_cnt=0; outputs axis_tvalid=0, axis_tlast=0, axis_user=0, axis_tdata=0, frame_done=0, s_ready=1 (after reset released and during reset). tstrb/tkeep all ones, tid/tdest 0 always.
- Latency: accept in cycle N → tvalid in N+1 (EMPTY state).
- Throughput: 1 pixel/cycle with tready held high; no bubble on simultaneous accept and transfer.
- Back-pressure: at most one extra accept after tready drops (lands in SKID); then s_ready=0 next cycle.
- Reset mid-frame: stored pixels discarded, counters restart; next accepted pixel carries sof.
- No data loss or duplication under any valid/ready pattern.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=2, tready=1, 8 pixels 0..7 back-to-back → output 0..7 from cycle 1, user=1 on 0 only, tlast on 3 and 7, frame_done pulse with 7, frame_cnt=1.
- Same config, tready=0 for 5 cycles from start, s_valid=1 → 2 pixels accepted, s_ready=0 from cycle 2; release tready → 0..7 in order, no gaps once streaming, tlast/user as above.
- Random s_valid and tready (50%) over 100 frames of 4×2 → scoreboard matches data order, tags; frame_cnt=100; tdata stable while tvalid&&!tready.
- arst asserted after pixel 5 of frame (3 in OUT/SKID) → tvalid=0 immediately; next pixels 100.. output with user=1 on 100, tlast on 103; frame_cnt=0.
- IMG_WIDTH=1, IMG_HEIGHT=1 → every pixel has user=1 and tlast=1, frame_done each transfer.
- CNT_WIDTH=2, 5 frames → frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/axis_video_framer.sv
// axis_video_framer
// Tags a raw pixel stream with start-of-frame / end-of-line markers based on
// column/row position and presents it on an AXI-stream master port. A
// two-entry buffer (output register plus skid register) keeps every master
// output registered while sustaining one transfer per cycle under
// back-pressure.

`timescale 1ns/1ps

`ifndef AXIS_DATA_WIDTH
`define AXIS_DATA_WIDTH 8
`endif

module axis_video_framer #(
   parameter int AXIS_DATA_WIDTH = `AXIS_DATA_WIDTH,
   parameter int IMG_WIDTH       = 2560,
   parameter int IMG_HEIGHT      = 1440,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                         aclk,
   input  logic                         arst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [AXIS_DATA_WIDTH-1:0]   s_data,
   output logic                         axis_tvalid,
   input  logic                         axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0]   axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0] axis_tstrb,
   output logic [AXIS_DATA_WIDTH/8-1:0] axis_tkeep,
   output logic                         axis_tlast,
   output logic                         axis_tid,
   output logic                         axis_tdest,
   output logic                         axis_user,
   output logic                         frame_done,
   output logic [CNT_WIDTH-1:0]         frame_cnt
);

   localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int STRB_W = AXIS_DATA_WIDTH / 8;

   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // One buffered pixel with its tags; flast marks the final pixel of a frame.
   typedef struct packed {
      logic                       flast;
      logic                       sof;
      logic                       eol;
      logic [AXIS_DATA_WIDTH-1:0] data;
   } entry_t;

   state_t                 state_q, state_d;
   entry_t                 out_q, out_d;
   entry_t                 skid_q, skid_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
   logic                   tvalid_q, tvalid_d;
   logic                   s_ready_q, s_ready_d;

   logic                   accept_s;
   logic                   xfer_s;
   entry_t                 new_s;

   assign accept_s = s_valid && s_ready_q;
   assign xfer_s   = tvalid_q && axis_tready;

   // Build the entry for the incoming pixel from the current position.
   always_comb begin
      new_s       = '0;
      new_s.data  = s_data;
      new_s.sof   = (col_q == {COL_W{1'b0}}) && (row_q == {ROW_W{1'b0}});
      new_s.eol   = (col_q == COL_MAX);
      new_s.flast = (col_q == COL_MAX) && (row_q == ROW_MAX);
   end

   // Advance column/row position on every accepted pixel.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept_s) begin
         if (col_q == COL_MAX) begin
            col_d = {COL_W{1'b0}};
            if (row_q == ROW_MAX) begin
               row_d = {ROW_W{1'b0}};
            end else begin
               row_d = row_q + ROW_W'(1);
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // Buffer occupancy FSM: decides which register loads and the next fill level.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               out_d   = new_s;
               state_d = ST_ONE;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && xfer_s) begin
               out_d   = new_s;
               state_d = ST_ONE;
            end else if (accept_s) begin
               skid_d  = new_s;
               state_d = ST_FULL;
            end else if (xfer_s) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_ONE;
            end
         end
         ST_FULL: begin
            // Upstream is stalled here, so only the drain path matters.
            if (xfer_s) begin
               out_d   = skid_q;
               state_d = ST_ONE;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Handshake flags are registered from the next state so neither depends
   // combinationally on axis_tready.
   always_comb begin
      tvalid_d  = (state_d != ST_EMPTY);
      s_ready_d = (state_d != ST_FULL);
   end

   // Completed-frame counter steps when the last pixel of a frame leaves.
   always_comb begin
      if (xfer_s && out_q.flast) begin
         frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   // State, buffer, position and counter registers.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state_q     <= ST_EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         col_q       <= {COL_W{1'b0}};
         row_q       <= {ROW_W{1'b0}};
         frame_cnt_q <= {CNT_WIDTH{1'b0}};
         tvalid_q    <= 1'b0;
         s_ready_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         col_q       <= col_d;
         row_q       <= row_d;
         frame_cnt_q <= frame_cnt_d;
         tvalid_q    <= tvalid_d;
         s_ready_q   <= s_ready_d;
      end
   end

   assign s_ready     = s_ready_q;
   assign axis_tvalid = tvalid_q;
   assign axis_tdata  = out_q.data;
   assign axis_tlast  = out_q.eol;
   assign axis_user   = out_q.sof;
   assign axis_tstrb  = {STRB_W{1'b1}};
   assign axis_tkeep  = {STRB_W{1'b1}};
   assign axis_tid    = 1'b0;
   assign axis_tdest  = 1'b0;
   // The frame-end tag is registered; the pulse qualifies it with the live
   // handshake so it lines up with the transfer itself.
   assign frame_done  = xfer_s && out_q.flast;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_axis_video_framer.sv
// Directed bench for axis_video_framer: a 4x2 instance exercises streaming,
// back-pressure, random handshakes and mid-frame reset against a queue model;
// a 1x1 instance with a 2-bit counter exercises degenerate sizes and wrap.

`timescale 1ns/1ps

module tb_axis_video_framer;

   localparam int DW = 8;

   logic          aclk = 1'b0;
   logic          arst;

   logic          s_valid, s_ready, axis_tready;
   logic [DW-1:0] s_data, axis_tdata;
   logic          axis_tvalid, axis_tlast, axis_tid, axis_tdest, axis_user, frame_done;
   logic [0:0]    axis_tstrb, axis_tkeep;
   logic [15:0]   frame_cnt;

   logic          s_valid1, s_ready1, axis_tready1;
   logic [DW-1:0] s_data1, axis_tdata1;
   logic          axis_tvalid1, axis_tlast1, axis_tid1, axis_tdest1, axis_user1, frame_done1;
   logic [0:0]    axis_tstrb1, axis_tkeep1;
   logic [1:0]    frame_cnt1;

   int            vectors = 0;
   int            miscompares = 0;

   logic [10:0]   sb_q[$];   // {flast, sof, eol, data}
   int            m_col = 0, m_row = 0, exp_fcnt = 0;
   bit            acc_s, xfer_s, rdy_s;
   int            xfer_total = 0, cyc = 0;
   bit            hold_v = 1'b0;
   logic [9:0]    hold_val;

   always #5 aclk = ~aclk;

   axis_video_framer #(.AXIS_DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(2), .CNT_WIDTH(16)) dut (
      .aclk(aclk), .arst(arst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
      .axis_tstrb(axis_tstrb), .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast),
      .axis_tid(axis_tid), .axis_tdest(axis_tdest), .axis_user(axis_user),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   axis_video_framer #(.AXIS_DATA_WIDTH(DW), .IMG_WIDTH(1), .IMG_HEIGHT(1), .CNT_WIDTH(2)) dut1 (
      .aclk(aclk), .arst(arst),
      .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
      .axis_tvalid(axis_tvalid1), .axis_tready(axis_tready1), .axis_tdata(axis_tdata1),
      .axis_tstrb(axis_tstrb1), .axis_tkeep(axis_tkeep1), .axis_tlast(axis_tlast1),
      .axis_tid(axis_tid1), .axis_tdest(axis_tdest1), .axis_user(axis_user1),
      .frame_done(frame_done1), .frame_cnt(frame_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock of the 4x2 instance: drive at the falling edge, then check
   // what the next rising edge will transfer and record what it will accept.
   task automatic cyc_step(input bit v, input logic [DW-1:0] d, input bit r);
      logic [10:0] e;
      bit          eol, sof, flast;
      @(negedge aclk);
      s_valid = v; s_data = d; axis_tready = r;
      #1;
      cyc++;
      rdy_s  = s_ready;
      acc_s  = s_valid && s_ready;
      xfer_s = axis_tvalid && axis_tready;
      if (hold_v) begin
         chk("hold_valid", axis_tvalid, 1);
         chk("hold_out", {axis_user, axis_tlast, axis_tdata}, hold_val);
      end
      chk("frame_cnt", frame_cnt, exp_fcnt[15:0]);
      if (xfer_s) begin
         chk("sb_nonempty", (sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("tdata", axis_tdata, e[7:0]);
            chk("tlast", axis_tlast, e[8]);
            chk("user", axis_user, e[9]);
            chk("frame_done", frame_done, e[10]);
            if (e[10]) exp_fcnt++;
            xfer_total++;
         end
      end else begin
         chk("frame_done_idle", frame_done, 0);
      end
      hold_v   = axis_tvalid && !axis_tready;
      hold_val = {axis_user, axis_tlast, axis_tdata};
      if (acc_s) begin
         eol   = (m_col == 3);
         sof   = (m_col == 0) && (m_row == 0);
         flast = eol && (m_row == 1);
         sb_q.push_back({flast, sof, eol, d});
         if (eol) begin
            m_col = 0;
            m_row = (m_row == 1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge aclk);
      arst = 1'b1; s_valid = 1'b0; s_valid1 = 1'b0;
      #1;
      chk("rst_tvalid", axis_tvalid, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_tdata", axis_tdata, 0);
      chk("rst_tlast", axis_tlast, 0);
      chk("rst_user", axis_user, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_tvalid1", axis_tvalid1, 0);
      sb_q.delete();
      m_col = 0; m_row = 0; exp_fcnt = 0; hold_v = 1'b0;
      @(negedge aclk);
      arst = 1'b0;
   endtask

   initial begin
      int pix, first_x, last_x, n, guard, start;
      arst = 1'b1;
      s_valid = 1'b0; s_data = '0; axis_tready = 1'b0;
      s_valid1 = 1'b0; s_data1 = '0; axis_tready1 = 1'b1;

      // Reset values and constant sideband
      apply_reset();
      chk("tstrb", axis_tstrb, 1);
      chk("tkeep", axis_tkeep, 1);
      chk("tid", axis_tid, 0);
      chk("tdest", axis_tdest, 0);

      // Test 1: 8 pixels back-to-back, tready high
      for (int k = 0; k < 8; k++) begin
         cyc_step(1'b1, DW'(k), 1'b1);
         chk("t1_accept", acc_s, 1);
         chk("t1_stream", xfer_s, (k > 0));
      end
      cyc_step(1'b0, 8'h00, 1'b1);
      chk("t1_xfers", xfer_total, 8);
      cyc_step(1'b0, 8'h00, 1'b1);
      chk("t1_frame_cnt", frame_cnt, 1);

      // Test 2: tready low for 5 cycles, s_valid held high
      pix = 0;
      start = xfer_total;
      for (int c = 0; c < 5; c++) begin
         cyc_step(1'b1, DW'(pix), 1'b0);
         chk("t2_s_ready", rdy_s, (c < 2));
         if (acc_s) pix++;
      end
      chk("t2_accepted", pix, 2);
      first_x = -1; last_x = -1; guard = 0;
      while ((xfer_total - start) < 8 && guard < 40) begin
         cyc_step((pix < 8), DW'(pix), 1'b1);
         if (acc_s) pix++;
         if (xfer_s) begin
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
         end
         guard++;
      end
      chk("t2_xfers", xfer_total - start, 8);
      chk("t2_no_gaps", last_x - first_x + 1, 8);
      cyc_step(1'b0, 8'h00, 1'b0);
      chk("t2_frame_cnt", frame_cnt, 2);

      // Test 3: random valid/ready over 100 frames
      n = 0; guard = 0; start = xfer_total;
      while ((xfer_total - start) < 800 && guard < 20000) begin
         cyc_step((n < 800) ? 1'($urandom_range(0, 1)) : 1'b0, n[7:0], 1'($urandom_range(0, 1)));
         if (acc_s) n++;
         guard++;
      end
      chk("t3_xfers", xfer_total - start, 800);
      cyc_step(1'b0, 8'h00, 1'b0);
      chk("t3_frame_cnt", frame_cnt, 102);

      // Test 4: reset mid-frame with pixels held in the buffer
      for (int k = 0; k < 5; k++) cyc_step(1'b1, DW'(k), 1'b1);
      cyc_step(1'b1, 8'd5, 1'b0);
      apply_reset();
      start = xfer_total;
      for (int k = 0; k < 8; k++) cyc_step(1'b1, DW'(100 + k), 1'b1);
      cyc_step(1'b0, 8'h00, 1'b1);
      chk("t4_xfers", xfer_total - start, 8);
      cyc_step(1'b0, 8'h00, 1'b1);
      chk("t4_frame_cnt", frame_cnt, 1);

      // Test 5: 1x1 image, 2-bit frame counter, 5 frames
      for (int k = 0; k < 6; k++) begin
         @(negedge aclk);
         s_valid1 = (k < 5); s_data1 = DW'(k);
         #1;
         chk("t5_s_ready", s_ready1, 1);
         if (k >= 1) begin
            chk("t5_tvalid", axis_tvalid1, 1);
            chk("t5_tdata", axis_tdata1, k - 1);
            chk("t5_user", axis_user1, 1);
            chk("t5_tlast", axis_tlast1, 1);
            chk("t5_frame_done", frame_done1, 1);
            chk("t5_frame_cnt", frame_cnt1, (k - 1) % 4);
         end
      end
      @(negedge aclk);
      s_valid1 = 1'b0;
      #1;
      chk("t5_final_cnt", frame_cnt1, 1);
      chk("t5_idle", axis_tvalid1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
